// File: rtl/ex_fwd_ctrl.sv
// Hazard and forwarding controller at the ID->EX boundary: registered EX operand
// selects, WB->ID regfile bypass, branch-kill and memory-stall sequencing.
module ex_fwd_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_a_pc,
    input  logic             id_b_imm,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_we,
    input  logic             ex_br_taken,
    input  logic             dmem_stall,
    output logic [1:0]       asel,
    output logic [1:0]       bsel,
    output logic             ex_valid,
    output logic             wb_valid,
    output logic             id_byp_rs1,
    output logic             id_byp_rs2,
    output logic             advance,
    output logic             flush_if,
    output logic [CNT_W-1:0] kill_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_KILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ret_kill;
    logic            w_ret_kill_nxt;
    logic [RA_W-1:0] r_ex_rd;
    logic            r_ex_we;
    logic [RA_W-1:0] r_wb_rd;
    logic            r_wb_we;

    logic w_br;
    logic w_kill_phase;
    logic w_squash;
    logic w_fwd_rs1;
    logic w_fwd_rs2;

    assign advance  = !dmem_stall;
    assign w_br     = ex_valid && ex_br_taken;
    assign flush_if = w_br && !dmem_stall;

    // A stall entered from KILL still owes the wrong-path squash once it releases.
    assign w_kill_phase = (r_state == ST_KILL) || ((r_state == ST_HOLD) && r_ret_kill);
    assign w_squash     = !id_valid || w_kill_phase || w_br;

    assign w_fwd_rs1 = id_use_rs1 && (id_rs1 != '0) && ex_valid && r_ex_we && (r_ex_rd == id_rs1);
    assign w_fwd_rs2 = id_use_rs2 && (id_rs2 != '0) && ex_valid && r_ex_we && (r_ex_rd == id_rs2);

    assign id_byp_rs1 = id_use_rs1 && (id_rs1 != '0) && wb_valid && r_wb_we && (r_wb_rd == id_rs1);
    assign id_byp_rs2 = id_use_rs2 && (id_rs2 != '0) && wb_valid && r_wb_we && (r_wb_rd == id_rs2);

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        w_state_nxt    = r_state;
        w_ret_kill_nxt = r_ret_kill;
        if (dmem_stall) begin
            if (r_state != ST_HOLD) begin
                w_state_nxt    = ST_HOLD;
                w_ret_kill_nxt = (r_state == ST_KILL);
            end
        end else if (w_br) begin
            w_state_nxt    = ST_KILL;
            w_ret_kill_nxt = 1'b0;
        end else begin
            w_state_nxt    = ST_RUN;
            w_ret_kill_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_ret_kill <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ret_kill <= w_ret_kill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asel     <= 2'b00;
            bsel     <= 2'b00;
            ex_valid <= 1'b0;
            r_ex_rd  <= '0;
            r_ex_we  <= 1'b0;
            wb_valid <= 1'b0;
            r_wb_rd  <= '0;
            r_wb_we  <= 1'b0;
            kill_cnt <= '0;
        end else if (advance) begin
            wb_valid <= ex_valid;
            r_wb_rd  <= r_ex_rd;
            r_wb_we  <= r_ex_we;
            r_ex_rd  <= id_rd;
            if (w_squash) begin
                ex_valid <= 1'b0;
                r_ex_we  <= 1'b0;
                asel     <= 2'b00;
                bsel     <= 2'b00;
            end else begin
                ex_valid <= 1'b1;
                r_ex_we  <= id_we;
                asel     <= {w_fwd_rs1, id_a_pc};
                bsel     <= {w_fwd_rs2, id_b_imm};
            end
            if (id_valid && w_squash && !(&kill_cnt))
                kill_cnt <= kill_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Self-checking bench for ex_fwd_ctrl: directed hazard scenarios plus random
// traffic compared against a slot-level pipeline model.
module tb_ex_fwd_ctrl;

    localparam int RA_W  = 5;
    localparam int CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            id_valid = 1'b0;
    logic [RA_W-1:0] id_rs1 = '0;
    logic [RA_W-1:0] id_rs2 = '0;
    logic            id_use_rs1 = 1'b0;
    logic            id_use_rs2 = 1'b0;
    logic            id_a_pc = 1'b0;
    logic            id_b_imm = 1'b0;
    logic [RA_W-1:0] id_rd = '0;
    logic            id_we = 1'b0;
    logic            ex_br_taken = 1'b0;
    logic            dmem_stall = 1'b0;
    logic [1:0]       asel;
    logic [1:0]       bsel;
    logic             ex_valid;
    logic             wb_valid;
    logic             id_byp_rs1;
    logic             id_byp_rs2;
    logic             advance;
    logic             flush_if;
    logic [CNT_W-1:0] kill_cnt;

    ex_fwd_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_a_pc(id_a_pc), .id_b_imm(id_b_imm), .id_rd(id_rd), .id_we(id_we),
        .ex_br_taken(ex_br_taken), .dmem_stall(dmem_stall),
        .asel(asel), .bsel(bsel), .ex_valid(ex_valid), .wb_valid(wb_valid),
        .id_byp_rs1(id_byp_rs1), .id_byp_rs2(id_byp_rs2),
        .advance(advance), .flush_if(flush_if), .kill_cnt(kill_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: one record per pipeline slot plus a count of owed wrong-path kills.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
    } slot_t;

    slot_t    m_ex, m_wb;
    bit [1:0] m_asel, m_bsel;
    int       m_kills_owed;
    int       m_kcnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ex = '{v: 1'b0, rd: 5'd0, we: 1'b0};
        m_wb = m_ex;
        m_asel = 2'b00;
        m_bsel = 2'b00;
        m_kills_owed = 0;
        m_kcnt = 0;
    endfunction

    function automatic bit reads_from(input bit use_r, input bit [4:0] rs, input slot_t s);
        return use_r && rs != 0 && s.v && s.we && s.rd == rs;
    endfunction

    task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                          input bit apc, input bit bimm, input int rd, input bit we);
        id_valid = v; id_rs1 = RA_W'(rs1); id_rs2 = RA_W'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2; id_a_pc = apc; id_b_imm = bimm;
        id_rd = RA_W'(rd); id_we = we;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        bit    br_act, kill;
        slot_t nxt_ex;
        #2;
        br_act = m_ex.v && ex_br_taken;
        check("flush_if", 32'(flush_if), 32'(br_act && !dmem_stall));
        check("advance", 32'(advance), 32'(!dmem_stall));
        check("byp_rs1", 32'(id_byp_rs1), 32'(reads_from(id_use_rs1, id_rs1, m_wb)));
        check("byp_rs2", 32'(id_byp_rs2), 32'(reads_from(id_use_rs2, id_rs2, m_wb)));
        @(posedge clk);
        if (!dmem_stall) begin
            kill = !id_valid || m_kills_owed > 0 || br_act;
            if (id_valid && kill && m_kcnt < 65535) m_kcnt++;
            nxt_ex = kill ? '{v: 1'b0, rd: id_rd, we: 1'b0} : '{v: 1'b1, rd: id_rd, we: id_we};
            m_asel = kill ? 2'b00 : {reads_from(id_use_rs1, id_rs1, m_ex), id_a_pc};
            m_bsel = kill ? 2'b00 : {reads_from(id_use_rs2, id_rs2, m_ex), id_b_imm};
            if (m_kills_owed > 0) m_kills_owed--;
            if (br_act) m_kills_owed = 1;
            m_wb = m_ex;
            m_ex = nxt_ex;
        end
        #1;
        check("asel", 32'(asel), 32'(m_asel));
        check("bsel", 32'(bsel), 32'(m_bsel));
        check("ex_valid", 32'(ex_valid), 32'(m_ex.v));
        check("wb_valid", 32'(wb_valid), 32'(m_wb.v));
        check("kill_cnt", 32'(kill_cnt), 32'(m_kcnt));
        @(negedge clk);
    endtask

    int       k0;
    bit [1:0] a_frz, b_frz;

    initial begin
        model_reset();
        #1;
        check("rst_asel", 32'(asel), 32'd0);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_kill_cnt", 32'(kill_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back dependency on x5, then the same shape on x0.
        set_id(1, 0, 0, 0, 0, 0, 0, 5, 1); step();
        set_id(1, 5, 0, 1, 0, 0, 0, 6, 1); step();
        check("b2b_asel", 32'(asel), 32'b10);
        check("b2b_ex_valid", 32'(ex_valid), 32'd1);
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
        set_id(1, 0, 0, 1, 0, 0, 0, 1, 1); step();
        check("x0_asel", 32'(asel), 32'b00);

        // Distance-2 dependency through the regfile bypass.
        set_id(1, 0, 0, 0, 0, 0, 0, 7, 1); step();
        set_id(1, 0, 0, 0, 0, 0, 0, 8, 1); step();
        set_id(1, 0, 7, 0, 1, 0, 0, 9, 0);
        #1 check("d2_byp_rs2", 32'(id_byp_rs2), 32'd1);
        step();
        check("d2_bsel1", 32'(bsel[1]), 32'd0);

        // Branch using PC as ALU A with a forwarded compare operand.
        set_id(1, 0, 0, 0, 0, 0, 0, 3, 1); step();
        set_id(1, 3, 0, 1, 0, 1, 0, 0, 0); step();
        check("br_pc_asel", 32'(asel), 32'b11);

        // Taken branch: two squashed slots, then back to normal flow.
        set_id(1, 1, 2, 1, 1, 0, 0, 0, 0); step();
        k0 = int'(kill_cnt);
        ex_br_taken = 1'b1;
        set_id(1, 0, 0, 0, 0, 0, 0, 4, 1);
        #1 check("tb_flush", 32'(flush_if), 32'd1);
        step();
        ex_br_taken = 1'b0;
        check("tb_bubble1", 32'(ex_valid), 32'd0);
        step();
        check("tb_bubble2", 32'(ex_valid), 32'd0);
        check("tb_kill2", 32'(kill_cnt), 32'(k0 + 2));
        step();
        check("tb_run", 32'(ex_valid), 32'd1);

        // Stall held three cycles over a taken branch.
        set_id(1, 4, 0, 1, 0, 1, 0, 0, 0); step();
        a_frz = asel; b_frz = bsel;
        ex_br_taken = 1'b1; dmem_stall = 1'b1;
        set_id(1, 0, 0, 0, 0, 0, 0, 2, 1);
        repeat (3) begin
            #1 check("st_flush", 32'(flush_if), 32'd0);
            step();
            check("st_asel", 32'(asel), 32'(a_frz));
            check("st_bsel", 32'(bsel), 32'(b_frz));
            check("st_ex_valid", 32'(ex_valid), 32'd1);
        end
        dmem_stall = 1'b0;
        #1 check("st_rel_flush", 32'(flush_if), 32'd1);
        step();
        ex_br_taken = 1'b0;
        #1 check("st_flush_once", 32'(flush_if), 32'd0);
        step(); step();

        // Asynchronous reset while in the KILL slot.
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        ex_br_taken = 1'b1; step();
        ex_br_taken = 1'b0;
        set_id(1, 6, 6, 1, 1, 1, 1, 6, 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_asel", 32'(asel), 32'd0);
        check("ar_bsel", 32'(bsel), 32'd0);
        check("ar_ex_valid", 32'(ex_valid), 32'd0);
        check("ar_wb_valid", 32'(wb_valid), 32'd0);
        check("ar_kill_cnt", 32'(kill_cnt), 32'd0);
        check("ar_flush", 32'(flush_if), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1, 0, 0, 0, 0, 0, 0, 6, 1); step();
        check("ar_run", 32'(ex_valid), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            set_id($urandom_range(99) < 80, int'($urandom_range(3)), int'($urandom_range(3)),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(3)), 1'($urandom));
            ex_br_taken = $urandom_range(99) < 20;
            dmem_stall  = $urandom_range(99) < 25;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
